// File: rtl/net_resolve_pkg.sv
// Shared types and resolution helpers for multi-driver net resolution.
package net_resolve_pkg;

  typedef enum logic [1:0] {
    ModeWor  = 2'd0,
    ModeWand = 2'd1,
    ModeTri0 = 2'd2,
    ModeTri1 = 2'd3
  } mode_e;

  // Upper bounds for the generic lane helper used by checkers.
  localparam int unsigned MaxNch = 16;
  localparam int unsigned MaxW   = 16;

  typedef struct packed {
    logic [MaxW-1:0] value;
    logic            undriven;
    logic            conflict;
  } lane_res_t;

  // Value a bit falls back to when undriven or (for tri modes) contested.
  function automatic logic pull_bit(input mode_e mode);
    return (mode == ModeWand) || (mode == ModeTri1);
  endfunction

  // Resolve one bit from the OR and AND of its enabled drivers.
  // An undriven bit has or=0/and=1, which lands on the pull value in every mode.
  function automatic logic resolve_bit(input mode_e mode, input logic or_b, input logic and_b);
    case (mode)
      ModeWor:  return or_b;
      ModeWand: return and_b;
      default:  return (or_b == and_b) ? or_b : pull_bit(mode);
    endcase
  endfunction

  // Whole-lane resolve; unused channels must have en=0, unused bits are don't-care.
  function automatic lane_res_t resolve_lane(input mode_e mode, input logic [MaxNch-1:0] en,
                                             input logic [MaxNch-1:0][MaxW-1:0] data);
    lane_res_t       res;
    logic [MaxW-1:0] or_v;
    logic [MaxW-1:0] and_v;
    or_v  = '0;
    and_v = '1;
    for (int unsigned c = 0; c < MaxNch; c++) begin
      if (en[c]) begin
        or_v  = or_v | data[c];
        and_v = and_v & data[c];
      end
    end
    for (int unsigned b = 0; b < MaxW; b++) begin
      res.value[b] = resolve_bit(mode, or_v[b], and_v[b]);
    end
    res.undriven = ~|en;
    res.conflict = (|en) & (|(or_v ^ and_v));
    return res;
  endfunction

endpackage

// File: rtl/net_resolve_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready depends only on registered state.
module net_resolve_skid #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] main_q, main_d, skid_q, skid_d;
  logic          main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic          push;

  assign in_ready  = ~skid_valid_q;
  assign push      = in_valid & ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

  // Next state: refill the output stage from skid first, else from input; park on stall.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_ready || !main_valid_q) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = push;
        if (push) main_d = in_data;
      end
    end else if (push) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/net_resolve_pipe.sv
// Registered multi-driver net resolver with conflict/undriven flags and valid/ready output.
module net_resolve_pipe
  import net_resolve_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned LANES = 4,
  parameter int unsigned W     = 3,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH-1:0]          drv_en,
  input  logic [LANES-1:0][W-1:0] drv_data [NCH],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0][W-1:0] out_data,
  output logic [LANES-1:0]        out_undriven,
  output logic [LANES-1:0]        out_conflict,
  output logic [CNT_W-1:0]        conflict_cnt,
  output logic                    conflict_sticky,
  input  logic                    clr
);

  localparam mode_e       Mode = mode_e'(MODE[1:0]);
  localparam int unsigned PW   = LANES * W + 2 * LANES;

  logic [LANES-1:0][W-1:0] res_data;
  logic [LANES-1:0]        res_und, res_con;
  logic                    accept;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W-1:0] dis;
    for (genvar b = 0; b < W; b++) begin : g_bit
      logic [NCH-1:0] col;
      logic           or_b, and_b;
      for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign col[c] = drv_data[c][l][b];
      end
      assign or_b            = |(col & drv_en);
      assign and_b           = &(col | ~drv_en);
      assign res_data[l][b]  = resolve_bit(Mode, or_b, and_b);
      assign dis[b]          = or_b ^ and_b;
    end
    assign res_und[l] = ~|drv_en;
    assign res_con[l] = (|drv_en) & (|dis);
  end

  assign accept = in_valid & in_ready;

  // Conflict statistics: saturating count and sticky flag; clr overrides a same-cycle event.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (accept && (|res_con)) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      sticky_d = 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign conflict_cnt    = cnt_q;
  assign conflict_sticky = sticky_q;

  net_resolve_skid #(
    .DW (PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({res_data, res_und, res_con}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_data, out_undriven, out_conflict})
  );

endmodule

// File: tb/tb_net_resolve_pipe.sv
// Scoreboard bench: four instances (one per mode, two with a 2-bit counter) share stimulus.
module tb_net_resolve_pipe;

  localparam int unsigned NCH   = 4;
  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 3;

  typedef struct packed {
    logic [NCH-1:0]                   en;
    logic [NCH-1:0][LANES-1:0][W-1:0] data;
  } word_t;

  logic                    clk, rst_n, in_valid, out_ready, clr;
  logic [NCH-1:0]          drv_en;
  logic [LANES-1:0][W-1:0] drv_data [NCH];

  logic                    ov  [4];
  logic                    ir  [4];
  logic                    stk [4];
  logic [LANES-1:0][W-1:0] od  [4];
  logic [LANES-1:0]        ou  [4];
  logic [LANES-1:0]        oc  [4];
  logic [7:0]              cnt [4];

  int    total = 0;
  int    bad   = 0;
  word_t q[$];
  int    ecnt [4];
  logic  estk [4];

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int unsigned Cw = (i >= 2) ? 2 : 8;
    logic [Cw-1:0] cnt_w;
    net_resolve_pipe #(
      .NCH   (NCH),
      .LANES (LANES),
      .W     (W),
      .MODE  (i),
      .CNT_W (Cw)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (ir[i]),
      .drv_en          (drv_en),
      .drv_data        (drv_data),
      .out_valid       (ov[i]),
      .out_ready       (out_ready),
      .out_data        (od[i]),
      .out_undriven    (ou[i]),
      .out_conflict    (oc[i]),
      .conflict_cnt    (cnt_w),
      .conflict_sticky (stk[i]),
      .clr             (clr)
    );
    assign cnt[i] = 8'(cnt_w);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", name, idx, act, exp, $time);
    end
  endtask

  // Reference: count enabled drivers and how many drive 1, then apply the net rules.
  function automatic void model(input int mode, input word_t wd,
                                output logic [LANES-1:0][W-1:0] val,
                                output logic [LANES-1:0] und, output logic [LANES-1:0] con);
    int n, k;
    logic pull, v;
    pull = (mode == 1) || (mode == 3);
    val = '0; und = '0; con = '0;
    n = 0;
    for (int c = 0; c < NCH; c++) if (wd.en[c]) n++;
    for (int l = 0; l < LANES; l++) begin
      und[l] = (n == 0);
      for (int b = 0; b < W; b++) begin
        k = 0;
        for (int c = 0; c < NCH; c++) if (wd.en[c] && wd.data[c][l][b]) k++;
        if (n == 0)        v = pull;
        else if (mode == 0) v = (k > 0);
        else if (mode == 1) v = (k == n);
        else if (k == 0)   v = 1'b0;
        else if (k == n)   v = 1'b1;
        else               v = pull;
        val[l][b] = v;
        if (k > 0 && k < n) con[l] = 1'b1;
      end
    end
  endfunction

  // Monitor: compare against the scoreboard head, then apply this cycle's handshakes.
  word_t                   mw;
  logic [LANES-1:0][W-1:0] ev;
  logic [LANES-1:0]        eu, ec;
  logic                    acc;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        check("out_valid", i, 64'(ov[i]), 64'(q.size() > 0));
        check("in_ready", i, 64'(ir[i]), 64'(q.size() < 2));
        check("conflict_cnt", i, 64'(cnt[i]), 64'(ecnt[i]));
        check("conflict_sticky", i, 64'(stk[i]), 64'(estk[i]));
        if (q.size() > 0) begin
          model(i, q[0], ev, eu, ec);
          check("out_data", i, 64'(od[i]), 64'(ev));
          check("out_undriven", i, 64'(ou[i]), 64'(eu));
          check("out_conflict", i, 64'(oc[i]), 64'(ec));
        end
      end
      acc = in_valid && (q.size() < 2);
      if (out_ready && q.size() > 0) void'(q.pop_front());
      ec = '0;
      if (acc) begin
        mw.en = drv_en;
        for (int c = 0; c < NCH; c++) mw.data[c] = drv_data[c];
        model(0, mw, ev, eu, ec);
        q.push_back(mw);
      end
      for (int i = 0; i < 4; i++) begin
        if (clr) begin
          ecnt[i] = 0;
          estk[i] = 1'b0;
        end else if (acc && (|ec)) begin
          if (ecnt[i] < ((i >= 2) ? 3 : 255)) ecnt[i]++;
          estk[i] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_word();
    drv_en = '0;
    for (int c = 0; c < NCH; c++) drv_data[c] = '0;
  endtask

  task automatic rand_word();
    drv_en = NCH'($urandom);
    for (int c = 0; c < NCH; c++) drv_data[c] = (LANES * W)'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ecnt[i] = 0;
      estk[i] = 1'b0;
    end
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    clear_word();
    #12;
    for (int i = 0; i < 4; i++) begin
      check("rst_out_valid", i, 64'(ov[i]), 64'(0));
      check("rst_cnt", i, 64'(cnt[i]), 64'(0));
      check("rst_sticky", i, 64'(stk[i]), 64'(0));
      check("rst_out_data", i, 64'(od[i]), 64'(0));
      check("rst_undriven", i, 64'(ou[i]), 64'(0));
      check("rst_conflict", i, 64'(oc[i]), 64'(0));
    end
    #10 rst_n = 1'b1;
    tick();

    // Directed words: WOR conflict, undriven, agreeing and disagreeing pairs.
    clear_word(); in_valid = 1'b1;
    drv_en = 4'b0101; drv_data[0][0] = 3'b001; drv_data[2][0] = 3'b100;
    tick();
    clear_word();
    tick();
    clear_word(); drv_en = 4'b0011; drv_data[0][1] = 3'b010; drv_data[1][1] = 3'b010;
    tick();
    drv_data[1][1] = 3'b101;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Stall: only two words may be held, then they drain in order.
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      rand_word(); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    // Random traffic with back-pressure and occasional clears.
    for (int j = 0; j < 2000; j++) begin
      rand_word();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clr       = ($urandom % 40) == 0;
      tick();
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    // Conflicting accept together with clr: clear must win.
    clear_word(); drv_en = 4'b0011; drv_data[0][0] = 3'b111;
    in_valid = 1'b1; clr = 1'b1;
    tick();
    in_valid = 1'b0; clr = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("clr_wins_cnt", i, 64'(cnt[i]), 64'(0));
      check("clr_wins_sticky", i, 64'(stk[i]), 64'(0));
    end
    repeat (2) tick();

    // Asynchronous reset while a word is held on the output.
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("async_rst_valid", i, 64'(ov[i]), 64'(0));
      check("async_rst_cnt", i, 64'(cnt[i]), 64'(0));
      check("async_rst_sticky", i, 64'(stk[i]), 64'(0));
    end
    q.delete();
    for (int i = 0; i < 4; i++) begin
      ecnt[i] = 0;
      estk[i] = 1'b0;
    end
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int j = 0; j < 60; j++) begin
      rand_word();
      in_valid  = ($urandom % 2) != 0;
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
